// File: rtl/kernel_sysid_checker.sv
// kernel_sysid_checker: Avalon-MM read initiator that fetches the system ID
// word (address 0) and build timestamp (address 1) and compares them against
// build-time expected values, retrying a bounded number of times on mismatch.
// Optional feature macro: SYSID_CHECK_TIMEOUT_EN (waitrequest timeout abort).

module kernel_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd1,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1503996230,
  parameter int unsigned READ_LATENCY       = 1,
  parameter int unsigned RETRY_MAX          = 3,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [3:0]  attempts,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 2;

  // Reject parameter values outside the supported ranges at elaboration.
  if (READ_LATENCY > 3 || RETRY_MAX > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("kernel_sysid_checker: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] lat_cnt;

  logic read_nxt;
  logic address_nxt;
  logic busy_nxt;
  logic done_nxt;

  logic accept_c;
  logic lat_hit_c;
  logic to_hit_c;
  logic id_mm_c;
  logic ts_mm_c;
  logic retry_c;

  assign accept_c  = read & ~waitrequest;
  assign lat_hit_c = (lat_cnt == LW'(READ_LATENCY));
  assign id_mm_c   = (captured_id != EXPECTED_ID);
  assign ts_mm_c   = (captured_ts != EXPECTED_TIMESTAMP);
  assign retry_c   = (id_mm_c | ts_mm_c) & (attempts <= AW'(RETRY_MAX));

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  assign to_hit_c = read & waitrequest & (to_cnt == TW'(TIMEOUT_CYCLES));

  // Count consecutive stalled read cycles; cleared on acceptance or idle bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (read && waitrequest && !to_hit_c) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit_c = 1'b0;
`endif

  // State register plus the registered bus/handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      read    <= 1'b0;
      address <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      read    <= read_nxt;
      address <= address_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_ID;
      end
      RD_ID: begin
        if (to_hit_c) begin
          state_nxt = DONE;
        end else if (accept_c) begin
          state_nxt = (READ_LATENCY == 0) ? RD_TS : WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (lat_hit_c) state_nxt = RD_TS;
      end
      RD_TS: begin
        if (to_hit_c) begin
          state_nxt = DONE;
        end else if (accept_c) begin
          state_nxt = (READ_LATENCY == 0) ? CHECK : WAIT_TS;
        end
      end
      WAIT_TS: begin
        if (lat_hit_c) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = retry_c ? RD_ID : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the outputs land registered.
  always_comb begin
    read_nxt    = 1'b0;
    address_nxt = 1'b0;
    busy_nxt    = 1'b1;
    done_nxt    = 1'b0;
    case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      RD_ID:   read_nxt = 1'b1;
      RD_TS: begin
        read_nxt    = 1'b1;
        address_nxt = 1'b1;
      end
      WAIT_TS: address_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: begin
        read_nxt    = 1'b0;
        address_nxt = 1'b0;
      end
    endcase
  end

  // Read-latency counter: counts cycles since acceptance in the WAIT states.
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if ((state == RD_ID || state == RD_TS) && accept_c) begin
      lat_cnt <= LW'(1);
    end else if ((state == WAIT_ID || state == WAIT_TS) && !lat_hit_c) begin
      lat_cnt <= lat_cnt + LW'(1);
    end else begin
      lat_cnt <= '0;
    end
  end

  // Capture of the ID and timestamp words at the data-valid edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      captured_id <= DW'(0);
      captured_ts <= DW'(0);
    end else begin
      if ((READ_LATENCY == 0 && state == RD_ID && accept_c) ||
          (state == WAIT_ID && lat_hit_c)) begin
        captured_id <= readdata;
      end
      if ((READ_LATENCY == 0 && state == RD_TS && accept_c) ||
          (state == WAIT_TS && lat_hit_c)) begin
        captured_ts <= readdata;
      end
    end
  end

  // Result flags and attempt counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      attempts    <= AW'(0);
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            attempts    <= AW'(1);
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RD_ID, RD_TS: begin
          if (to_hit_c) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        CHECK: begin
          id_mismatch <= id_mm_c;
          ts_mismatch <= ts_mm_c;
          if (retry_c) begin
            if (attempts != {AW{1'b1}}) attempts <= attempts + AW'(1);
          end else begin
            pass <= ~(id_mm_c | ts_mm_c);
          end
        end
        default: begin
          pass <= pass;
        end
      endcase
    end
  end

endmodule
